sdram_burst_buffer: RTL

- Downstream stage of the SDRAM read controller.
- Captures the 16-bit read-burst words qualified by the controller's data-available strobe into an on-chip FIFO, then presents them to the pixel/display pipeline with a valid/ready handshake.
- Generates the controller's pause/unpause flow-control pulses from FIFO fill level, so a burst is never issued into a FIFO that cannot absorb it.

---
 rtl/sdram_burst_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_buffer.sv
// SDRAM read-burst capture FIFO with registered show-ahead output.
// Optional stats outputs (max_level, drop_count) under `BURST_BUFFER_STATS_EN.
module sdram_burst_buffer #(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = 8,
  parameter int HIGH_MARK = 48,
  parameter int LOW_MARK  = 16
) (
  input  logic                     ck143,
  input  logic                     reset,
  input  logic                     burst_valid,
  input  logic [15:0]              burst_data,
  output logic                     pause,
  output logic                     unpause,
  output logic                     pix_valid,
  output logic [15:0]              pix_data,
  input  logic                     pix_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     burst_done,
  output logic                     overflow
`ifdef BURST_BUFFER_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   max_level,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] HI   = LW'(HIGH_MARK);
  localparam logic [LW-1:0] LO   = LW'(LOW_MARK);
  localparam logic [BW-1:0] BLST = BW'(BURST_LEN - 1);

  typedef enum logic {
    RUN,
    PAUSED
  } state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [LW-1:0] st_cnt;
  logic [BW-1:0] bcnt;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic          accept;
  logic          load;
  logic          st_empty;
  state_t        state;
  state_t        state_nxt;
  logic          pause_d;
  logic          unpause_d;

  // level counts storage plus the output register
  assign full      = (level == FULL);
  assign wr_en     = burst_valid && !full;
  assign drop      = burst_valid && full;
  assign accept    = pix_valid && pix_ready;
  assign st_cnt    = level - LW'(pix_valid);
  assign st_empty  = (st_cnt == '0);
  assign load      = (!pix_valid || pix_ready) && !st_empty;
  assign level_nxt = level + LW'(wr_en) - LW'(accept);

  // storage array write port (no reset needed on data)
  always_ff @(posedge ck143) begin
    if (wr_en) mem[wr_ptr] <= burst_data;
  end

  // pointers and occupancy
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end
  end

  // show-ahead output register, held while stalled
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (load) begin
      pix_valid <= 1'b1;
      pix_data  <= mem[rd_ptr];
    end else if (accept) begin
      pix_valid <= 1'b0;
    end
  end

  // burst word counter and done pulse; dropped words still count
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      bcnt       <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_valid && (bcnt == BLST);
      if (burst_valid) begin
        if (bcnt == BLST) bcnt <= '0;
        else              bcnt <= bcnt + 1'b1;
      end
    end
  end

  // sticky overflow flag
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // flow FSM state and registered pulses
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pause   <= 1'b0;
      unpause <= 1'b0;
    end else begin
      state   <= state_nxt;
      pause   <= pause_d;
      unpause <= unpause_d;
    end
  end

  // flow FSM next state from post-update level
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:    if (level_nxt >= HI) state_nxt = PAUSED;
      PAUSED: if (level_nxt <= LO) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // flow FSM pulse decode: one pulse per transition
  always_comb begin
    pause_d   = 1'b0;
    unpause_d = 1'b0;
    unique case (1'b1)
      (state == RUN)    && (state_nxt == PAUSED): pause_d   = 1'b1;
      (state == PAUSED) && (state_nxt == RUN):    unpause_d = 1'b1;
      default: ;
    endcase
  end

`ifdef BURST_BUFFER_STATS_EN
  // high-water mark and saturating drop counter
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      max_level  <= '0;
      drop_count <= '0;
    end else begin
      if (level_nxt > max_level) max_level <= level_nxt;
      if (drop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
